// File: rtl/instr_encoder.sv
// Purpose : encodes symbolic MIPS instructions and writes them to consecutive instruction-memory words.
// Latency : an accept in cycle N drives mem_we/mem_addr/mem_wdata in cycle N+1; one instruction per cycle.
// Backpr. : in_ready drops once the final instruction (in_last or DEPTH-th) is accepted, and stays low in DONE/ERR.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     instruction handshake; fields in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last
//   mem_we/addr/wdata     single-cycle write strobe, word address, encoded instruction
//   count                 words written this session
//   done / err            sticky session-complete / unsupported-op flags (cleared only by reset)
module instr_encoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_op,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_shamt,
    input  logic [15:0]           in_imm,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] LP_BASE  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_DONE = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_stop_pending;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [ADDR_WIDTH:0]   r_count;

    logic                  w_op_ok;
    logic                  w_rtype;
    logic [5:0]            w_funct;
    logic [5:0]            w_opcode;
    logic [4:0]            w_rs;
    logic [4:0]            w_rt;
    logic [4:0]            w_rd;
    logic [4:0]            w_shamt;
    logic [31:0]           w_word;
    logic                  w_accept;
    logic                  w_acc_ok;
    logic                  w_acc_bad;

    // Opcode/funct lookup and field forcing.
    always_comb begin
        w_op_ok  = 1'b1;
        w_rtype  = 1'b1;
        w_funct  = 6'h00;
        w_opcode = 6'b000000;
        case (in_op)
            5'd0:    w_funct = 6'h20;
            5'd1:    w_funct = 6'h22;
            5'd2:    w_funct = 6'h24;
            5'd3:    w_funct = 6'h25;
            5'd4:    w_funct = 6'h26;
            5'd5:    w_funct = 6'h27;
            5'd6:    w_funct = 6'h2A;
            5'd7:    w_funct = 6'h2B;
            5'd8:    w_funct = 6'h00;
            5'd9:    w_funct = 6'h02;
            5'd10:   w_funct = 6'h03;
            5'd11:   w_funct = 6'h04;
            5'd12:   w_funct = 6'h06;
            5'd13:   w_funct = 6'h08;
            5'd14:   begin w_rtype = 1'b0; w_opcode = 6'b001000; end
            5'd15:   begin w_rtype = 1'b0; w_opcode = 6'b001010; end
            5'd16:   begin w_rtype = 1'b0; w_opcode = 6'b001100; end
            5'd17:   begin w_rtype = 1'b0; w_opcode = 6'b001101; end
            5'd18:   begin w_rtype = 1'b0; w_opcode = 6'b001110; end
            5'd19:   begin w_rtype = 1'b0; w_opcode = 6'b100011; end
            5'd20:   begin w_rtype = 1'b0; w_opcode = 6'b101011; end
            5'd21:   begin w_rtype = 1'b0; w_opcode = 6'b000100; end
            5'd22:   begin w_rtype = 1'b0; w_opcode = 6'b000101; end
            default: begin w_rtype = 1'b0; w_op_ok = 1'b0; end
        endcase

        // Constant shifts carry no rs; every other R-type carries no shamt;
        // jr carries only rs.
        w_rs    = in_rs;
        w_rt    = in_rt;
        w_rd    = in_rd;
        w_shamt = 5'd0;
        if (in_op == 5'd8 || in_op == 5'd9 || in_op == 5'd10) begin
            w_rs    = 5'd0;
            w_shamt = in_shamt;
        end
        if (in_op == 5'd13) begin
            w_rt = 5'd0;
            w_rd = 5'd0;
        end

        if (w_rtype) begin
            w_word = {6'b000000, w_rs, w_rt, w_rd, w_shamt, w_funct};
        end else begin
            w_word = {w_opcode, in_rs, in_rt, in_imm};
        end
    end

    assign w_accept  = in_valid && in_ready;
    assign w_acc_ok  = w_accept && w_op_ok;
    assign w_acc_bad = w_accept && !w_op_ok;

    // DONE follows one cycle after the final write (stop_pending is already
    // set while that write is on the bus).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RUN: begin
                if (w_acc_bad) begin
                    w_next_state = S_ERR;
                end else if (r_stop_pending) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_DONE;
            S_ERR:   w_next_state = S_ERR;
            default: w_next_state = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_RUN;
            r_stop_pending <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= LP_BASE;
            r_wdata        <= 32'd0;
            r_count        <= '0;
        end else begin
            r_state <= w_next_state;
            r_we    <= w_acc_ok;
            if (w_acc_ok) begin
                // r_count still holds this word's index; address wraps naturally.
                r_addr  <= LP_BASE + r_count[ADDR_WIDTH-1:0];
                r_wdata <= w_word;
                r_count <= r_count + 1'b1;
                if (in_last || (r_count + 1'b1) == LP_DEPTH) begin
                    r_stop_pending <= 1'b1;
                end
            end
        end
    end

    // Gating with reset discards a write that is on the bus while reset is held.
    assign mem_we    = r_we && !reset;
    assign in_ready  = !reset && (r_state == S_RUN) && !r_stop_pending;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign count     = r_count;
    assign done      = (r_state == S_DONE);
    assign err       = (r_state == S_ERR);

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clk;
    int          n_cmp;
    int          n_err;

    // DUT A: default parameters
    logic        a_reset, a_in_valid, a_in_ready, a_in_last;
    logic [4:0]  a_in_op, a_in_rs, a_in_rt, a_in_rd, a_in_shamt;
    logic [15:0] a_in_imm;
    logic        a_mem_we, a_done, a_err;
    logic [7:0]  a_mem_addr;
    logic [31:0] a_mem_wdata;
    logic [8:0]  a_count;

    // DUT B: DEPTH=4, BASE_ADDR=254
    logic        b_reset, b_in_valid, b_in_ready, b_in_last;
    logic [4:0]  b_in_op, b_in_rs, b_in_rt, b_in_rd, b_in_shamt;
    logic [15:0] b_in_imm;
    logic        b_mem_we, b_done, b_err;
    logic [7:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [8:0]  b_count;

    instr_encoder #(.ADDR_WIDTH(8), .DEPTH(256), .BASE_ADDR(0)) u_dut_a (
        .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_op(a_in_op), .in_rs(a_in_rs), .in_rt(a_in_rt), .in_rd(a_in_rd),
        .in_shamt(a_in_shamt), .in_imm(a_in_imm), .in_last(a_in_last),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .count(a_count), .done(a_done), .err(a_err)
    );

    instr_encoder #(.ADDR_WIDTH(8), .DEPTH(4), .BASE_ADDR(254)) u_dut_b (
        .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_op(b_in_op), .in_rs(b_in_rs), .in_rt(b_in_rt), .in_rd(b_in_rd),
        .in_shamt(b_in_shamt), .in_imm(b_in_imm), .in_last(b_in_last),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .count(b_count), .done(b_done), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                          input logic last);
        a_in_valid = 1'b1;
        a_in_op    = op;
        a_in_rs    = rs;
        a_in_rt    = rt;
        a_in_rd    = rd;
        a_in_shamt = sh;
        a_in_imm   = imm;
        a_in_last  = last;
    endtask

    task automatic idle_a();
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
    endtask

    initial begin
        logic [7:0] b_exp_addr [4];
        b_exp_addr = '{8'd254, 8'd255, 8'd0, 8'd1};
        n_cmp = 0;
        n_err = 0;

        a_reset = 1'b1; b_reset = 1'b1;
        a_in_valid = 0; a_in_op = 0; a_in_rs = 0; a_in_rt = 0; a_in_rd = 0;
        a_in_shamt = 0; a_in_imm = 0; a_in_last = 0;
        b_in_valid = 0; b_in_op = 0; b_in_rs = 0; b_in_rt = 0; b_in_rd = 0;
        b_in_shamt = 0; b_in_imm = 0; b_in_last = 0;
        tick();
        tick();

        // Reset state
        chk("rst_ready", a_in_ready, 0);
        chk("rst_we",    a_mem_we, 0);
        chk("rst_addr",  a_mem_addr, 0);
        chk("rst_wdata", a_mem_wdata, 0);
        chk("rst_count", a_count, 0);
        chk("rst_done",  a_done, 0);
        chk("rst_err",   a_err, 0);
        a_reset = 1'b0;
        b_reset = 1'b0;
        #1;
        chk("ready_after_rst", a_in_ready, 1);

        // Single encodes, streamed back-to-back
        send_a(5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 16'h0000, 1'b0);      // add
        tick();
        chk("add_we",    a_mem_we, 1);
        chk("add_addr",  a_mem_addr, 0);
        chk("add_wdata", a_mem_wdata, 32'h00221820);
        chk("add_count", a_count, 1);
        send_a(5'd19, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 1'b0);    // lw
        tick();
        chk("lw_addr",  a_mem_addr, 1);
        chk("lw_wdata", a_mem_wdata, 32'h8FA80004);
        send_a(5'd8, 5'd7, 5'd2, 5'd2, 5'd4, 16'h0000, 1'b0);      // sll
        tick();
        chk("sll_wdata", a_mem_wdata, 32'h00021100);
        chk("sll_count", a_count, 3);
        send_a(5'd13, 5'd31, 5'd5, 5'd6, 5'd7, 16'h0000, 1'b0);    // jr
        tick();
        chk("jr_wdata", a_mem_wdata, 32'h03E00008);
        send_a(5'd10, 5'd9, 5'd3, 5'd4, 5'd31, 16'h0000, 1'b0);    // sra
        tick();
        chk("sra_wdata", a_mem_wdata, 32'h000327C3);
        chk("sra_addr",  a_mem_addr, 4);
        chk("sra_count", a_count, 5);
        idle_a();
        tick();
        chk("idle_we",    a_mem_we, 0);
        chk("idle_addr",  a_mem_addr, 4);
        chk("idle_wdata", a_mem_wdata, 32'h000327C3);

        // Three back-to-back with in_last on the third
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        send_a(5'd21, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 1'b0);     // beq
        tick();
        chk("beq_we",    a_mem_we, 1);
        chk("beq_addr",  a_mem_addr, 0);
        chk("beq_wdata", a_mem_wdata, 32'h1022FFFF);
        send_a(5'd17, 5'd3, 5'd4, 5'd0, 5'd0, 16'h00FF, 1'b0);     // ori
        tick();
        chk("ori_addr",  a_mem_addr, 1);
        chk("ori_wdata", a_mem_wdata, 32'h346400FF);
        send_a(5'd20, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0010, 1'b1);   // sw, last
        tick();
        chk("sw_we",    a_mem_we, 1);
        chk("sw_addr",  a_mem_addr, 2);
        chk("sw_wdata", a_mem_wdata, 32'hAFBF0010);
        chk("sw_ready", a_in_ready, 0);
        chk("sw_count", a_count, 3);
        chk("sw_done",  a_done, 0);
        send_a(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 1'b0);      // must be ignored
        tick();
        chk("fin_we",    a_mem_we, 0);
        chk("fin_done",  a_done, 1);
        chk("fin_count", a_count, 3);
        tick();
        chk("fin_we2",   a_mem_we, 0);
        chk("fin_done2", a_done, 1);
        idle_a();

        // Invalid op after a valid add
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        send_a(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 1'b0);
        tick();
        chk("pre_bad_we",   a_mem_we, 1);
        chk("pre_bad_addr", a_mem_addr, 0);
        send_a(5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1234, 1'b1);
        tick();
        chk("bad_we",    a_mem_we, 0);
        chk("bad_err",   a_err, 1);
        chk("bad_ready", a_in_ready, 0);
        chk("bad_count", a_count, 1);
        chk("bad_done",  a_done, 0);
        send_a(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 1'b0);
        tick();
        chk("err_we",    a_mem_we, 0);
        chk("err_count", a_count, 1);
        chk("err_stick", a_err, 1);
        idle_a();
        a_reset = 1'b1;
        tick();
        chk("clr_err",   a_err, 0);
        chk("clr_count", a_count, 0);
        chk("clr_addr",  a_mem_addr, 0);
        a_reset = 1'b0;

        // Reset in the cycle after an accept
        send_a(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 1'b0);
        tick();
        idle_a();
        a_reset = 1'b1;
        #1;
        chk("midrst_we", a_mem_we, 0);
        tick();
        a_reset = 1'b0;
        send_a(5'd1, 5'd4, 5'd5, 5'd6, 5'd3, 16'h0000, 1'b0);      // sub, shamt dropped
        tick();
        chk("sub_we",    a_mem_we, 1);
        chk("sub_addr",  a_mem_addr, 0);
        chk("sub_count", a_count, 1);
        chk("sub_wdata", a_mem_wdata, 32'h00853022);
        idle_a();

        // DEPTH=4 with wrap from BASE_ADDR=254, valid held 6 cycles
        b_reset = 1'b1;
        tick();
        b_reset = 1'b0;
        b_in_valid = 1'b1;
        b_in_op = 5'd0; b_in_rs = 5'd1; b_in_rt = 5'd2; b_in_rd = 5'd3;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i < 4) begin
                chk($sformatf("dep_we%0d", i),    b_mem_we, 1);
                chk($sformatf("dep_addr%0d", i),  b_mem_addr, b_exp_addr[i]);
                chk($sformatf("dep_count%0d", i), b_count, i + 1);
                chk($sformatf("dep_wdata%0d", i), b_mem_wdata, 32'h00221820);
            end else begin
                chk($sformatf("dep_we%0d", i),    b_mem_we, 0);
                chk($sformatf("dep_done%0d", i),  b_done, 1);
                chk($sformatf("dep_count%0d", i), b_count, 4);
            end
            if (i == 3) begin
                chk("dep_ready_low", b_in_ready, 0);
                chk("dep_done_early", b_done, 0);
            end
        end
        b_in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
